// File: rtl/prog_lut_pkg.sv
// prog_lut_pkg: shared state encoding and sizing helpers for the programmable LUT.
package prog_lut_pkg;

    typedef enum logic [1:0] {EMPTY, LOAD, ARMED} state_t;

    function automatic int depth(input int n);
        return 1 << n;
    endfunction

    // Each table entry stores {val, dc}, so it is twice the function count wide.
    function automatic int entry_w(input int m);
        return 2 * m;
    endfunction

endpackage

// File: rtl/lut_table.sv
// lut_table: flop-array truth table with async clear, one sync write port and a combinational read port.
module lut_table
    import prog_lut_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [depth(AW)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth(AW); i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_lut.sv
// prog_lut: run-time loadable N-input, M-output truth table with don't-care plane and registered evaluate.
// Define LUT_DC_HOLD_EN to hold the previous f bit for don't-care entries instead of driving DC_FILL.
module prog_lut
    import prog_lut_pkg::*;
#(
    parameter int   N       = 4,
    parameter int   M       = 1,
    parameter logic DC_FILL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_start,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [M-1:0] cfg_val,
    input  logic [M-1:0] cfg_dc,
    output logic         cfg_done,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    output logic         out_valid,
    output logic [M-1:0] f,
    output logic [M-1:0] f_dc,
    output logic         busy,
    output logic         miss
);

    state_t                  state, state_nxt;
    logic [N-1:0]            ptr;
    logic [entry_w(M)-1:0]   rdata;
    logic [M-1:0]            rd_val, rd_dc, f_nxt;
    logic                    wr, last, armed;

    assign cfg_ready = (state == LOAD) && !cfg_start;
    assign wr        = cfg_valid && cfg_ready;
    assign last      = &ptr;
    assign armed     = state == ARMED;
    assign rd_val    = rdata[entry_w(M)-1:M];
    assign rd_dc     = rdata[M-1:0];
    assign state_nxt = cfg_start ? LOAD : (wr && last) ? ARMED : state;

`ifdef LUT_DC_HOLD_EN
    assign f_nxt = (rd_val & ~rd_dc) | (f & rd_dc);
`else
    assign f_nxt = (rd_val & ~rd_dc) | ({M{DC_FILL}} & rd_dc);
`endif

    lut_table #(.AW(N), .DW(entry_w(M))) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr),
        .waddr (ptr),
        .wdata ({cfg_val, cfg_dc}),
        .raddr (a),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ptr       <= '0;
            cfg_done  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            miss      <= 1'b0;
            f         <= '0;
            f_dc      <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= cfg_start ? '0 : wr ? ptr + 1'b1 : ptr;
            cfg_done  <= wr && last;
            busy      <= state_nxt == LOAD;
            out_valid <= in_valid && armed;
            miss      <= in_valid && !armed;
            if (in_valid && armed) begin
                f    <= f_nxt;
                f_dc <= rd_dc;
            end
        end
    end

endmodule
